tag_bank_fill_ctrl: RTL
=======================

# tag_bank_fill_ctrl

Write-side controller for the two-way tag store of the cache. It tracks per-set valid and LRU state and qualifies the raw tag-compare results from both tag banks into a registered hit and way select, which drives the bank read mux SEL. On a miss it chooses a victim way, fetches the line from memory over a req/ack handshake, and issues a single-cycle write enable to exactly one tag bank.

## Interface
- TAG_W, 14, tag width; must match the tag bank width.
- IDX_W, 4, set index width; 2^IDX_W sets.

- CLK  in  1  clock; everything is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- LOOKUP_VALID  in  1  lookup request; sampled only when BUSY=0.
- LOOKUP_IDX  in  IDX_W  set index of the lookup.
- LOOKUP_TAG  in  TAG_W  tag of the lookup.
- CMP1, CMP2  in  1  raw tag-equal from bank 1 / bank 2 for LOOKUP_IDX, same cycle as LOOKUP_VALID.
- FLUSH  in  1  invalidate all sets and abort any fill.
- MEM_ACK  in  1  memory has returned the line.
- HIT  out  1  registered hit pulse.
- HIT_WAY  out  1  way that hit: 0=bank 1, 1=bank 2; read-mux SEL.
- BUSY  out  1  fill in progress; lookups ignored.
- MEM_REQ  out  1  memory read request.
- MEM_ADDR  out  TAG_W+IDX_W  {tag, idx} of the missing line.
- WE1, WE2  out  1  tag write enable for bank 1 / bank 2.
- W_IDX  out  IDX_W  write index.
- W_TAG  out  TAG_W  write tag.
- FILL_DONE  out  1  one-cycle pulse when the fill completes.
- FILL_WAY  out  1  victim way of the current or last fill.

## Operation
- Per-set state: V1[s], V2[s] valid bits and LRU[s]. LRU[s] is the way to evict next.
- Qualified hits: h1 = CMP1&V1[idx] and h2 = CMP2&V2[idx]. If both are set, way 0 wins (h1 has priority).
- FSM states are IDLE, REQ and FILL.
- IDLE, lookup with a hit:
  - Next cycle: HIT=1 for one cycle and HIT_WAY = hitting way.
  - LRU[idx] is set to the other way.
  - State stays IDLE.
- IDLE, lookup with a miss:
  - Latch idx and tag.
  - Victim = way 0 if !V1[idx]; else way 1 if !V2[idx]; else LRU[idx].
  - Latch the victim into FILL_WAY and go to REQ.
- REQ:
  - MEM_REQ=1 and MEM_ADDR = latched {tag, idx}, both held stable until MEM_ACK.
  - When MEM_ACK=1 is sampled, go to FILL.
- FILL (exactly one cycle):
  - Assert only the victim's WE (WE1 for way 0, WE2 for way 1), with W_IDX/W_TAG = latched values.
  - Set the victim's valid bit, set LRU[idx] = other way, pulse FILL_DONE, go to IDLE.
- BUSY=1 in REQ and FILL. LOOKUP_VALID is ignored while BUSY.
- FLUSH (any state):
  - Next edge clears all V and LRU bits and returns to IDLE.
  - MEM_REQ, WE*, HIT and FILL_DONE deassert; no bank write happens.
  - FLUSH beats a simultaneous LOOKUP_VALID or MEM_ACK.
- MEM_ACK outside REQ is ignored.
- WE1 and WE2 are never asserted together.

## Timing
- Reset values:
  - HIT, BUSY, MEM_REQ, WE1, WE2, FILL_DONE, FILL_WAY, HIT_WAY = 0.
  - MEM_ADDR, W_IDX, W_TAG = 0.
  - All V and LRU = 0; state IDLE.
- RST mid-fill behaves like FLUSH.
- Hit latency: 1 cycle from the lookup edge to HIT.
- Miss: MEM_REQ rises 1 cycle after the lookup, and BUSY rises in the same cycle.
- Ack to write: WE is high in the cycle after MEM_ACK is sampled. FILL_DONE is high in that same cycle. BUSY drops the cycle after.
- Minimum miss turnaround, with MEM_ACK already high in the first REQ cycle: lookup at t, MEM_REQ at t+1, WE/FILL_DONE at t+2, next lookup accepted at t+3.
- All outputs are registered. None depends combinationally on inputs.

## Test plan
- Cold miss: after reset, lookup idx=3, tag=0x1A2B, CMP1=CMP2=0 -> MEM_REQ=1 with MEM_ADDR={0x1A2B,3}. With ack after 4 cycles -> WE1=1, W_IDX=3, W_TAG=0x1A2B, FILL_DONE=1, FILL_WAY=0.
- Second miss, same set: lookup idx=3, tag=0x0055 -> fills way 1 (WE2). A third miss, tag=0x0077, evicts way 0 (LRU=0 after the second fill).
- Hit and LRU update: with both ways valid in set 3, lookup with CMP1=1 -> HIT=1, HIT_WAY=0 the next cycle. A following miss on set 3 fills way 1.
- Double compare: CMP1=CMP2=1 on a valid set -> HIT_WAY=0.
- Busy drop: lookup during REQ -> no HIT, no state change, MEM_ADDR unchanged.
- Flush/reset mid-fill: FLUSH in REQ together with MEM_ACK=1 -> no WE, no FILL_DONE, BUSY=0 next cycle. The next lookup on a previously valid set misses and fills way 0. Repeat with RST for the same result.

Source files
------------

// File: rtl/tag_bank_fill_ctrl_if.sv
// Lookup, memory-fill and tag-bank write signals of the two-way tag store controller.
// The slave modport belongs to the controller; the master modport is the cache datapath side.
interface tag_bank_fill_ctrl_if #(
  parameter int unsigned TagW = 14,
  parameter int unsigned IdxW = 4
);
  logic                 lookup_valid;
  logic [IdxW-1:0]      lookup_idx;
  logic [TagW-1:0]      lookup_tag;
  logic                 cmp1;
  logic                 cmp2;
  logic                 flush;
  logic                 mem_ack;
  logic                 hit;
  logic                 hit_way;
  logic                 busy;
  logic                 mem_req;
  logic [TagW+IdxW-1:0] mem_addr;
  logic                 we1;
  logic                 we2;
  logic [IdxW-1:0]      w_idx;
  logic [TagW-1:0]      w_tag;
  logic                 fill_done;
  logic                 fill_way;

  modport slave (
    input  lookup_valid, lookup_idx, lookup_tag, cmp1, cmp2, flush, mem_ack,
    output hit, hit_way, busy, mem_req, mem_addr, we1, we2, w_idx, w_tag, fill_done, fill_way
  );

  modport master (
    output lookup_valid, lookup_idx, lookup_tag, cmp1, cmp2, flush, mem_ack,
    input  hit, hit_way, busy, mem_req, mem_addr, we1, we2, w_idx, w_tag, fill_done, fill_way
  );
endinterface

// File: rtl/tag_bank_fill_ctrl.sv
// Two-way tag store controller: qualifies bank compares into a registered hit, and on a miss
// picks a victim, fetches the line over req/ack and writes exactly one tag bank for one cycle.
module tag_bank_fill_ctrl #(
  parameter int unsigned TagW = 14,
  parameter int unsigned IdxW = 4
) (
  input logic                  clk,
  input logic                  rst,
  tag_bank_fill_ctrl_if.slave  bus
);
  localparam int unsigned NumSets = 1 << IdxW;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e             state_q;
  logic [NumSets-1:0] v1_q;
  logic [NumSets-1:0] v2_q;
  logic [NumSets-1:0] lru_q;

  logic            h1;
  logic            h2;
  logic            victim;
  logic [IdxW-1:0] fill_idx;
  logic [TagW-1:0] fill_tag;

  // mem_addr doubles as the latch for the missing line's tag and index.
  assign fill_idx = bus.mem_addr[IdxW-1:0];
  assign fill_tag = bus.mem_addr[TagW+IdxW-1:IdxW];

  always_comb begin
    h1     = bus.cmp1 & v1_q[bus.lookup_idx];
    h2     = bus.cmp2 & v2_q[bus.lookup_idx];
    victim = 1'b0;
    if (!v1_q[bus.lookup_idx]) begin
      victim = 1'b0;
    end else if (!v2_q[bus.lookup_idx]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[bus.lookup_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      v1_q          <= '0;
      v2_q          <= '0;
      lru_q         <= '0;
      bus.hit       <= 1'b0;
      bus.hit_way   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.we1       <= 1'b0;
      bus.we2       <= 1'b0;
      bus.w_idx     <= '0;
      bus.w_tag     <= '0;
      bus.fill_done <= 1'b0;
      bus.fill_way  <= 1'b0;
    end else if (bus.flush) begin
      // Abort: drop any fill in flight without writing a bank.
      state_q       <= StIdle;
      v1_q          <= '0;
      v2_q          <= '0;
      lru_q         <= '0;
      bus.hit       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.we1       <= 1'b0;
      bus.we2       <= 1'b0;
      bus.fill_done <= 1'b0;
    end else begin
      bus.hit       <= 1'b0;
      bus.we1       <= 1'b0;
      bus.we2       <= 1'b0;
      bus.fill_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.lookup_valid) begin
            if (h1 || h2) begin
              bus.hit                <= 1'b1;
              bus.hit_way            <= ~h1;
              lru_q[bus.lookup_idx]  <= h1;
            end else begin
              bus.mem_addr <= {bus.lookup_tag, bus.lookup_idx};
              bus.fill_way <= victim;
              bus.mem_req  <= 1'b1;
              bus.busy     <= 1'b1;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (bus.mem_ack) begin
            bus.mem_req   <= 1'b0;
            bus.we1       <= ~bus.fill_way;
            bus.we2       <= bus.fill_way;
            bus.w_idx     <= fill_idx;
            bus.w_tag     <= fill_tag;
            bus.fill_done <= 1'b1;
            if (bus.fill_way) begin
              v2_q[fill_idx] <= 1'b1;
            end else begin
              v1_q[fill_idx] <= 1'b1;
            end
            lru_q[fill_idx] <= ~bus.fill_way;
            state_q         <= StFill;
          end
        end
        StFill: begin
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule
